train_pulse_seq: RTL

Sequencer for the training-phase write pulses of the synapse array. During the training system state it steps the DAC top-level state through the two-polarity pulse program and generates the per-phase `pulse17_state` / `pulse27_state` codes. These outputs drive every array switch cell, e.g. the cell that drives `in15`, which decode them into switch levels. It owns all pulse timing; switch cells only decode.

---
 rtl/train_pulse_seq.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/train_pulse_seq.sv
// train_pulse_seq: training-phase write pulse sequencer for the synapse array.
// Steps the DAC top-level state through a two-polarity pulse program and
// produces the per-phase pulse17/pulse27 codes that the switch cells decode.
// Optional feature: define TRAIN_SEQ_READ_EN to insert the V_READ state
// between the last CNT_2_2 and COMPLETE.
module train_pulse_seq #(
  parameter int CNT_W     = 16,
  parameter int T_SETUP   = 2,
  parameter int T_PULSE   = 4,
  parameter int T_RELEASE = 2,
  parameter int T_GAP     = 3,
  parameter int T_V2      = 5,
  parameter int N_PULSE   = 2,
  parameter int T_READ    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] system_state,
  input  logic       key_state,
  input  logic       start,
  output logic [3:0] dac_top_state,
  output logic [1:0] pulse17_state,
  output logic [1:0] pulse27_state,
  output logic [7:0] pulse_cnt,
  output logic       busy,
  output logic       done
);

  // State codes are shared with the switch cells and must not change.
  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    V1_2     = 4'd1,
    CNT_1_2  = 4'd2,
    V2_2     = 4'd3,
    CNT_2_2  = 4'd4,
    V_READ   = 4'd5,
    COMPLETE = 4'd6,
    V1_1     = 4'd7,
    V2_1     = 4'd8,
    CNT_1_1  = 4'd9,
    CNT_2_1  = 4'd10
  } state_t;

  // Pulse phase encoding used on pulse17_state / pulse27_state.
  localparam logic [1:0] PH_OFF     = 2'd0;
  localparam logic [1:0] PH_SETUP   = 2'd1;
  localparam logic [1:0] PH_ACTIVE  = 2'd2;
  localparam logic [1:0] PH_RELEASE = 2'd3;

  // Terminal counts: a timer starts at 0 on entry and expires at T-1.
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(T_PULSE - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(T_RELEASE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] V2_LAST      = CNT_W'(T_V2 - 1);
`ifdef TRAIN_SEQ_READ_EN
  localparam logic [CNT_W-1:0] READ_LAST    = CNT_W'(T_READ - 1);
`endif
  localparam logic [8:0]       N_PULSE_W    = 9'(N_PULSE);

  state_t           state, state_n;
  logic [CNT_W-1:0] tmr, tmr_n;
  logic [1:0]       phase, phase_n;
  logic [7:0]       cnt_n;
  logic [CNT_W-1:0] phase_last;
  logic             run;
  logic             last_rep;

  assign run           = key_state && (system_state == 3'd2);
  assign dac_top_state = state;
  assign last_rep      = !(({1'b0, pulse_cnt} + 9'd1) < N_PULSE_W);

  // Terminal count for the pulse phase currently being driven inside V1_x.
  always_comb begin
    phase_last = SETUP_LAST;
    case (phase)
      PH_ACTIVE:  phase_last = PULSE_LAST;
      PH_RELEASE: phase_last = RELEASE_LAST;
      default:    phase_last = SETUP_LAST;
    endcase
  end

  // Next-state logic: advance the program, reload timers on every transition,
  // and fall back to IDLE on abort or on an illegal state code.
  always_comb begin
    state_n = state;
    tmr_n   = tmr + CNT_W'(1);
    phase_n = phase;
    cnt_n   = pulse_cnt;

    case (state)
      IDLE: begin
        tmr_n   = '0;
        phase_n = PH_OFF;
        cnt_n   = '0;
        if (run && start) begin
          state_n = V1_1;
          phase_n = PH_SETUP;
        end
      end

      V1_1, V1_2: begin
        if (tmr == phase_last) begin
          tmr_n = '0;
          if (phase == PH_RELEASE) begin
            phase_n = PH_OFF;
            state_n = (state == V1_1) ? CNT_1_1 : CNT_1_2;
          end else begin
            phase_n = phase + 2'd1;
          end
        end
      end

      CNT_1_1, CNT_1_2: begin
        if (tmr == GAP_LAST) begin
          tmr_n   = '0;
          state_n = (state == CNT_1_1) ? V2_1 : V2_2;
        end
      end

      V2_1, V2_2: begin
        if (tmr == V2_LAST) begin
          tmr_n   = '0;
          state_n = (state == V2_1) ? CNT_2_1 : CNT_2_2;
        end
      end

      CNT_2_1: begin
        if (tmr == GAP_LAST) begin
          tmr_n   = '0;
          phase_n = PH_SETUP;
          if (last_rep) begin
            cnt_n   = '0;
            state_n = V1_2;
          end else begin
            cnt_n   = pulse_cnt + 8'd1;
            state_n = V1_1;
          end
        end
      end

      CNT_2_2: begin
        if (tmr == GAP_LAST) begin
          tmr_n = '0;
          if (last_rep) begin
            cnt_n = '0;
`ifdef TRAIN_SEQ_READ_EN
            state_n = V_READ;
`else
            state_n = COMPLETE;
`endif
          end else begin
            cnt_n   = pulse_cnt + 8'd1;
            phase_n = PH_SETUP;
            state_n = V1_2;
          end
        end
      end

`ifdef TRAIN_SEQ_READ_EN
      V_READ: begin
        if (tmr == READ_LAST) begin
          tmr_n   = '0;
          state_n = COMPLETE;
        end
      end
`endif

      COMPLETE: begin
        tmr_n   = '0;
        state_n = IDLE;
      end

      default: begin
        tmr_n   = '0;
        phase_n = PH_OFF;
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase

    if ((state != IDLE) && !run) begin
      state_n = IDLE;
      tmr_n   = '0;
      phase_n = PH_OFF;
      cnt_n   = '0;
    end
  end

  // State register with registered outputs derived from the next state, so
  // pulse codes change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tmr           <= '0;
      phase         <= PH_OFF;
      pulse_cnt     <= '0;
      pulse17_state <= PH_OFF;
      pulse27_state <= PH_OFF;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      tmr           <= tmr_n;
      phase         <= phase_n;
      pulse_cnt     <= cnt_n;
      pulse17_state <= (state_n == V1_1) ? phase_n : PH_OFF;
      pulse27_state <= (state_n == V1_2) ? phase_n : PH_OFF;
      busy          <= (state_n != IDLE);
      done          <= (state_n == COMPLETE);
    end
  end

endmodule
